traffic_phase_scheduler: RTL
============================

# traffic_phase_scheduler

Intersection scheduler that sequences the NS/EW signal heads and shares the crossing among three requesters: NS vehicle sensor, EW vehicle sensor, and pedestrian push-button. It generates its own phase tick from `clk` with a prescaler. It enforces minimum and maximum green, yellow, and all-red clearance, and inserts an all-red walk phase on demand. It replaces the fixed-cycle light at the top of the traffic design and drives the lamp outputs directly.

## Interface
- `TICK_DIV`, 4: clk cycles per phase tick; must be ≥2.
- `G_MIN`, 2: minimum green length in ticks; must be ≥1.
- `G_MAX`, 5: maximum green length in ticks; must satisfy G_MIN ≤ G_MAX.
- `Y_TICKS`, 2: yellow length in ticks; must be ≥1.
- `AR_TICKS`, 1: all-red clearance length in ticks; must be ≥1.
- `WALK_TICKS`, 3: pedestrian walk length in ticks; must be ≥1.
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `ns_req` input 1: NS vehicle present; level or pulse, sampled every clk.
- `ew_req` input 1: EW vehicle present; level or pulse, sampled every clk.
- `ped_req` input 1: pedestrian button; pulse of ≥1 clk, sampled every clk.
- `ns_g`, `ns_y`, `ns_r` output 1 each: NS lamps; exactly one is high.
- `ew_g`, `ew_y`, `ew_r` output 1 each: EW lamps; exactly one is high.
- `walk` output 1: pedestrian walk lamp.
- `tick` output 1: one-clk prescaler pulse, exported for the display logic.
- `phase` output 3: encoded state: 0 NS_G, 1 NS_Y, 2 AR, 3 EW_G, 4 EW_Y, 5 PED.

## Operation
- Prescaler counts 0..TICK_DIV-1 and wraps. `tick`=1 in the cycle the count equals TICK_DIV-1.
- Phase counter `pc` is sized with $clog2 of the largest duration parameter.
  - It increments on `tick`.
  - It is cleared to 0 on every state transition.
  - State changes happen only on `tick` cycles.
- Pending flags `ns_pend`, `ew_pend`, `ped_pend`:
  - `ns_pend` is set by `ns_req` in any state except NS_G. It is cleared on the cycle NS_G is entered.
  - `ew_pend` is the symmetric case for EW_G.
  - `ped_pend` is set by `ped_req` in any state except PED. It is cleared on the cycle PED is entered.
  - On an entry cycle, clear wins over a same-cycle set.
- `last_dir` register: 0 = NS, 1 = EW. It is updated on entry to NS_G or EW_G.
- Transitions. All are evaluated on `tick` and use pending values registered before that cycle.
  - NS_G → NS_Y when `pc`==G_MAX-1, or when `pc`≥G_MIN-1 and (`ew_pend` or `ped_pend`).
  - NS_Y → AR when `pc`==Y_TICKS-1.
  - EW_G → EW_Y: symmetric to NS_G, using `ns_pend` or `ped_pend`.
  - EW_Y → AR when `pc`==Y_TICKS-1.
  - AR → PED when `pc`==AR_TICKS-1 and `ped_pend`=1. Otherwise AR → EW_G if `last_dir`=NS, or AR → NS_G if `last_dir`=EW.
  - PED → EW_G if `last_dir`=NS, or PED → NS_G if `last_dir`=EW, when `pc`==WALK_TICKS-1.
- Lamp decode from state:
  - `ns_g`=NS_G, `ns_y`=NS_Y, `ns_r`=all other states.
  - `ew_g`=EW_G, `ew_y`=EW_Y, `ew_r`=all other states.
  - `walk`=PED.
- With no requests, greens run to G_MAX and the light alternates NS/EW indefinitely. Requests only shorten a green; they never extend it.
- A request from the currently green direction is ignored and not latched.

## Timing
- Reset values:
  - state NS_G, `pc`=0, prescaler=0, all pending flags 0, `last_dir`=NS.
  - Outputs: `ns_g`=1, `ew_r`=1, all other lamps 0, `walk`=0, `tick`=0, `phase`=0.
- The first `tick` occurs at clk cycle TICK_DIV-1 after the first cycle with `rst` low.
- Phase length is exactly N·TICK_DIV clk cycles, where N is the tick count for that phase. The new state is visible on the cycle after the transition tick.
- A request is latched on the clk after it is asserted. A request in the same cycle as a tick does not affect that tick's decision.
- Mid-operation reset: on the next clk, the block returns to the reset values regardless of state. Pending requests are lost.
- Simultaneous `ped_pend` and opposite-vehicle pending: PED is served first, then the opposite green.
- `ped_req` during PED: ignored; no second walk phase.

## Test plan
Default parameters for all scenarios.
1. **Idle cycling.** Reset, no requests.
   - NS_G lasts 20 clks, NS_Y 8, AR 4, then EW_G 20, EW_Y 8, AR 4, then NS_G.
   - `tick` every 4 clks.
2. **Early exit.** `ew_req` pulsed 1 clk during NS_G tick 0.
   - NS_G ends after 2 ticks (8 clks) → NS_Y.
   - `ew_pend` clears on EW_G entry.
3. **Pedestrian.** `ped_req` during EW_G.
   - EW_G ends at G_MIN, then EW_Y → AR → PED with `walk`=1 and all red for 12 clks.
   - Then NS_G.
4. **Simultaneous requests.** `ped_req` and `ew_req` in the same clk during NS_G.
   - Sequence NS_Y → AR → PED → EW_G.
   - A second `ped_req` during PED causes no extra PED.
5. **Mid-phase reset.** `rst` asserted in EW_Y.
   - Next clk: `ns_g`=1, `ew_r`=1, `phase`=0.
   - Pending flags 0; the first tick comes 4 clks after `rst` falls.
6. **Own-direction request.** `ns_req` held high throughout NS_G.
   - NS_G lasts the full G_MAX (20 clks).
   - `ns_pend` stays 0.

Source files
------------

// File: rtl/traffic_phase_scheduler_if.sv
// Request inputs and lamp/status outputs of the intersection phase scheduler.
// master = controller/environment side, slave = scheduler side.
interface traffic_phase_scheduler_if;
  logic       ns_req;
  logic       ew_req;
  logic       ped_req;
  logic       ns_g;
  logic       ns_y;
  logic       ns_r;
  logic       ew_g;
  logic       ew_y;
  logic       ew_r;
  logic       walk;
  logic       tick;
  logic [2:0] phase;

  modport master (
    output ns_req, ew_req, ped_req,
    input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, tick, phase
  );

  modport slave (
    input  ns_req, ew_req, ped_req,
    output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, tick, phase
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Demand-responsive intersection sequencer: NS/EW greens bounded by min/max,
// yellow and all-red clearance, and an on-demand all-red pedestrian walk.
module traffic_phase_scheduler #(
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned G_MIN      = 2,
  parameter int unsigned G_MAX      = 5,
  parameter int unsigned Y_TICKS    = 2,
  parameter int unsigned AR_TICKS   = 1,
  parameter int unsigned WALK_TICKS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  traffic_phase_scheduler_if.slave   bus
);

  localparam int unsigned MAX_GY = (G_MAX > Y_TICKS) ? G_MAX : Y_TICKS;
  localparam int unsigned MAX_AW = (AR_TICKS > WALK_TICKS) ? AR_TICKS : WALK_TICKS;
  localparam int unsigned MAX_D  = (MAX_GY > MAX_AW) ? MAX_GY : MAX_AW;
  localparam int unsigned PC_W   = (MAX_D > 1) ? $clog2(MAX_D) : 1;
  localparam int unsigned PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_NS_G = 3'd0,
    S_NS_Y = 3'd1,
    S_AR   = 3'd2,
    S_EW_G = 3'd3,
    S_EW_Y = 3'd4,
    S_PED  = 3'd5
  } state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [PS_W-1:0]   r_presc;
  logic              r_tick;
  logic              r_ns_pend;
  logic              r_ew_pend;
  logic              r_ped_pend;
  logic              r_last_dir;
  logic              r_ns_g, r_ns_y, r_ns_r;
  logic              r_ew_g, r_ew_y, r_ew_r;
  logic              r_walk;
  logic [2:0]        r_phase;

  state_t            w_next_state;
  logic              w_change;
  state_t            w_resume;

  // After clearance or walk, serve the direction that did not have the last green.
  assign w_resume = r_last_dir ? S_NS_G : S_EW_G;
  assign w_change = (w_next_state != r_state);

  // Next-state decision; only moves on a tick, using pending flags latched earlier.
  always_comb begin
    w_next_state = r_state;
    if (r_tick) begin
      case (r_state)
        S_NS_G: begin
          if ((r_pc == PC_W'(G_MAX - 1)) ||
              ((r_pc >= PC_W'(G_MIN - 1)) && (r_ew_pend || r_ped_pend)))
            w_next_state = S_NS_Y;
        end
        S_NS_Y: begin
          if (r_pc == PC_W'(Y_TICKS - 1)) w_next_state = S_AR;
        end
        S_EW_G: begin
          if ((r_pc == PC_W'(G_MAX - 1)) ||
              ((r_pc >= PC_W'(G_MIN - 1)) && (r_ns_pend || r_ped_pend)))
            w_next_state = S_EW_Y;
        end
        S_EW_Y: begin
          if (r_pc == PC_W'(Y_TICKS - 1)) w_next_state = S_AR;
        end
        S_AR: begin
          if (r_pc == PC_W'(AR_TICKS - 1))
            w_next_state = r_ped_pend ? S_PED : w_resume;
        end
        S_PED: begin
          if (r_pc == PC_W'(WALK_TICKS - 1)) w_next_state = w_resume;
        end
        default: w_next_state = S_NS_G;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_NS_G;
      r_pc       <= '0;
      r_presc    <= '0;
      r_tick     <= 1'b0;
      r_ns_pend  <= 1'b0;
      r_ew_pend  <= 1'b0;
      r_ped_pend <= 1'b0;
      r_last_dir <= 1'b0;
      r_ns_g     <= 1'b1;
      r_ns_y     <= 1'b0;
      r_ns_r     <= 1'b0;
      r_ew_g     <= 1'b0;
      r_ew_y     <= 1'b0;
      r_ew_r     <= 1'b1;
      r_walk     <= 1'b0;
      r_phase    <= 3'd0;
    end else begin
      // r_tick is high exactly while the prescaler sits at TICK_DIV-1.
      r_presc <= r_tick ? '0 : r_presc + PS_W'(1);
      r_tick  <= (r_presc == PS_W'(TICK_DIV - 2));

      r_state <= w_next_state;
      if (w_change)    r_pc <= '0;
      else if (r_tick) r_pc <= r_pc + PC_W'(1);

      // Entry clears beat a same-cycle request; own-direction requests are dropped.
      if (w_change && (w_next_state == S_NS_G))      r_ns_pend <= 1'b0;
      else if (bus.ns_req && (r_state != S_NS_G))    r_ns_pend <= 1'b1;

      if (w_change && (w_next_state == S_EW_G))      r_ew_pend <= 1'b0;
      else if (bus.ew_req && (r_state != S_EW_G))    r_ew_pend <= 1'b1;

      if (w_change && (w_next_state == S_PED))       r_ped_pend <= 1'b0;
      else if (bus.ped_req && (r_state != S_PED))    r_ped_pend <= 1'b1;

      if (w_change && (w_next_state == S_NS_G))      r_last_dir <= 1'b0;
      else if (w_change && (w_next_state == S_EW_G)) r_last_dir <= 1'b1;

      r_ns_g  <= (w_next_state == S_NS_G);
      r_ns_y  <= (w_next_state == S_NS_Y);
      r_ns_r  <= (w_next_state != S_NS_G) && (w_next_state != S_NS_Y);
      r_ew_g  <= (w_next_state == S_EW_G);
      r_ew_y  <= (w_next_state == S_EW_Y);
      r_ew_r  <= (w_next_state != S_EW_G) && (w_next_state != S_EW_Y);
      r_walk  <= (w_next_state == S_PED);
      r_phase <= w_next_state;
    end
  end

  assign bus.ns_g  = r_ns_g;
  assign bus.ns_y  = r_ns_y;
  assign bus.ns_r  = r_ns_r;
  assign bus.ew_g  = r_ew_g;
  assign bus.ew_y  = r_ew_y;
  assign bus.ew_r  = r_ew_r;
  assign bus.walk  = r_walk;
  assign bus.tick  = r_tick;
  assign bus.phase = r_phase;

endmodule
